// File: rtl/edge_accum_buffer.sv
// -----------------------------------------------------------------------------
// edge_accum_buffer
//
// Per-node feature-vector accumulator between an Edge PE and its consumers.
// The Edge PE streams LANES elements per beat over one or more passes; every
// element is added (saturating or wrapping) into a MAX_FV-deep buffer. On
// command the accumulated vector is streamed to the output buffer (with
// request/grant and ready backpressure) or to the Reservation Station
// (request/grant, one beat per cycle).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_sos/in_eos          input beat valid / first / last beat of pass
//   in_data                         LANES elements, lane k at [k*DATA_W +: DATA_W]
//   in_node_id                      node id, captured on the first beat of a pass
//   wb_en, done_aggr                commands, honoured only while holding a vector
//   ob_req/ob_grant                 write-back request / grant
//   ob_valid/ob_sos/ob_eos/ob_ready write-back stream flags and acceptance
//   ob_data, ob_node_id             write-back payload
//   rs_req/rs_grant                 RS request / grant
//   rs_valid/rs_sos/rs_eos          RS stream flags
//   rs_data, rs_node_id             RS payload
//   busy                            block is not idle
//   len_err                         sticky protocol error (length/overflow/sos)
// -----------------------------------------------------------------------------
module edge_accum_buffer #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 8,
    parameter int MAX_FV  = 16,
    parameter int NODE_W  = 8,
    parameter bit SAT     = 1'b1,
    parameter bit WB_KEEP = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sos,
    input  logic                    in_eos,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [NODE_W-1:0]       in_node_id,
    input  logic                    wb_en,
    input  logic                    done_aggr,
    output logic                    ob_req,
    input  logic                    ob_grant,
    output logic                    ob_valid,
    output logic                    ob_sos,
    output logic                    ob_eos,
    input  logic                    ob_ready,
    output logic [LANES*DATA_W-1:0] ob_data,
    output logic [NODE_W-1:0]       ob_node_id,
    output logic                    rs_req,
    input  logic                    rs_grant,
    output logic                    rs_valid,
    output logic                    rs_sos,
    output logic                    rs_eos,
    output logic [LANES*DATA_W-1:0] rs_data,
    output logic [NODE_W-1:0]       rs_node_id,
    output logic                    busy,
    output logic                    len_err
);

    localparam int MAX_BEATS = MAX_FV / LANES;
    localparam int PTR_W     = $clog2(MAX_FV + 1);
    // One spare count above MAX_BEATS so an over-long pass still compares unequal.
    localparam int BEAT_W    = $clog2(MAX_BEATS + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_HOLD, S_WB_REQ, S_WB_OUT, S_RS_REQ, S_RS_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_W-1:0]         acc_q [MAX_FV];
    logic [DATA_W-1:0]         acc_d [MAX_FV];
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;   // beats in current pass, or read-out beat index
    logic [BEAT_W-1:0]         len_q, len_d;     // 0 means no pass length recorded yet
    logic [NODE_W-1:0]         node_q, node_d;
    logic                      err_q, err_d;

    logic                      take, first, clear;
    int                        base;
    logic [BEAT_W-1:0]         cnt, beat_inc;
    logic                      rd_sos, rd_eos;
    logic [LANES*DATA_W-1:0]   rd_data;

    function automatic logic [DATA_W-1:0] add_elem(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Signed overflow shows as the two top bits of the extended sum disagreeing.
        if (SAT && (s[DATA_W] != s[DATA_W-1]))
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal written in this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        ptr_d      = ptr_q;
        beat_d     = beat_q;
        len_d      = len_q;
        node_d     = node_q;
        err_d      = err_q;
        take       = 1'b0;
        first      = 1'b0;
        clear      = 1'b0;
        base       = 0;
        cnt        = '0;
        ob_req     = 1'b0;
        ob_valid   = 1'b0;
        ob_sos     = 1'b0;
        ob_eos     = 1'b0;
        ob_data    = '0;
        ob_node_id = '0;
        rs_req     = 1'b0;
        rs_valid   = 1'b0;
        rs_sos     = 1'b0;
        rs_eos     = 1'b0;
        rs_data    = '0;
        rs_node_id = '0;

        beat_inc = (beat_q == '1) ? beat_q : beat_q + 1'b1;
        rd_sos   = (beat_q == '0);
        rd_eos   = ((beat_q + 1'b1) == len_q);
        rd_data  = '0;
        for (int k = 0; k < LANES; k++)
            if (int'(ptr_q) + k < MAX_FV)
                rd_data[k*DATA_W +: DATA_W] = acc_q[int'(ptr_q) + k];

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_sos) begin
                    take  = 1'b1;
                    first = 1'b1;
                end
            end
            S_HOLD: begin
                if (done_aggr)
                    state_d = S_RS_REQ;
                else if (wb_en)
                    state_d = S_WB_REQ;
                else if (in_valid && in_sos) begin
                    take  = 1'b1;
                    first = 1'b1;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    take = 1'b1;
                    if (in_sos)
                        err_d = 1'b1;
                end
            end
            S_WB_REQ: begin
                ob_req = 1'b1;
                if (ob_grant) begin
                    ptr_d   = '0;
                    beat_d  = '0;
                    state_d = S_WB_OUT;
                end
            end
            S_WB_OUT: begin
                ob_valid   = 1'b1;
                ob_sos     = rd_sos;
                ob_eos     = rd_eos;
                ob_data    = rd_data;
                ob_node_id = node_q;
                if (ob_ready) begin
                    if (rd_eos) begin
                        if (WB_KEEP)
                            state_d = S_HOLD;
                        else begin
                            clear   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        ptr_d  = ptr_q + PTR_W'(LANES);
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_RS_REQ: begin
                rs_req = 1'b1;
                if (rs_grant) begin
                    ptr_d   = '0;
                    beat_d  = '0;
                    state_d = S_RS_OUT;
                end
            end
            S_RS_OUT: begin
                rs_valid   = 1'b1;
                rs_sos     = rd_sos;
                rs_eos     = rd_eos;
                rs_data    = rd_data;
                rs_node_id = node_q;
                if (rd_eos) begin
                    clear   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ptr_d  = ptr_q + PTR_W'(LANES);
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            base = first ? 0 : int'(ptr_q);
            cnt  = first ? BEAT_W'(1) : beat_inc;
            if (first)
                node_d = in_node_id;
            // A full buffer drops the beat but it still counts toward the pass length.
            if (base >= MAX_FV)
                err_d = 1'b1;
            else begin
                for (int k = 0; k < LANES; k++)
                    acc_d[base + k] = add_elem(acc_q[base + k], in_data[k*DATA_W +: DATA_W]);
                ptr_d = PTR_W'(base + LANES);
            end
            beat_d = cnt;
            if (in_eos) begin
                state_d = S_HOLD;
                if (len_q == '0)
                    len_d = BEAT_W'(int'(ptr_d) / LANES);
                else if (cnt != len_q)
                    err_d = 1'b1;
            end else
                state_d = S_ACCUM;
        end

        if (clear) begin
            for (int i = 0; i < MAX_FV; i++)
                acc_d[i] = '0;
            len_d = '0;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign len_err = err_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            node_q  <= '0;
            err_q   <= 1'b0;
            // NOTE: the buffer itself is reset because passes add into it; stale contents would corrupt the next vector.
            for (int i = 0; i < MAX_FV; i++)
                acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            node_q  <= node_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

endmodule
